// File: rtl/alu_share_pkg.sv
// alu_share_pkg
//   Shared definitions for the two-requester ALU arbiter and its ALU core:
//   - default datapath widths,
//   - FSM state encoding,
//   - ALU operation codes,
//   - a small one-hot helper for the requester id.
package alu_share_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int OP_W_DEF    = 3;
  localparam int SHAMT_W_DEF = 4;

  typedef logic [1:0] state_t;

  // FSM encoding; 2'd3 is unused and recovers to IDLE.
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // ALU operation codes. Every 3-bit code has a defined meaning.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  // Requester id (0/1) to its one-hot handshake bit.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// alu_core
//   Purely combinational 16-bit ALU with shifter.
//   Ports:
//     a, b   : operands
//     op     : operation select (alu_share_pkg OP_* codes)
//     bneg   : inverts B with carry-in 1 (two's-complement negate) on the adder,
//              plain inversion for the logic ops
//     shamt  : shift amount applied to A for the shift ops
//     result : operation result
//     zero   : result == 0
//     ovf    : signed overflow of the adder (adder ops only)
//     cout   : carry out of the adder (adder ops only)
module alu_core
  import alu_share_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [OP_W-1:0]    op,
  input  logic               bneg,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               ovf,
  output logic               cout
);

  logic              negate_s;
  logic [DATA_W-1:0] b_eff_s;
  logic [DATA_W:0]   sum_s;

  // Operation decode, adder, logic unit and shifter.
  always_comb begin
    // SUB always subtracts; bneg lets any op see an inverted B.
    negate_s = bneg | (op == OP_SUB);
    b_eff_s  = negate_s ? ~b : b;
    sum_s    = {1'b0, a} + {1'b0, b_eff_s} + {{DATA_W{1'b0}}, negate_s};
    result   = {DATA_W{1'b0}};
    ovf      = 1'b0;
    cout     = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum_s[DATA_W-1:0];
        cout   = sum_s[DATA_W];
        // Overflow: operands agree in sign, sum disagrees.
        ovf    = (a[DATA_W-1] == b_eff_s[DATA_W-1]) &&
                 (sum_s[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result = a & b_eff_s;
      OP_OR:   result = a | b_eff_s;
      OP_XOR:  result = a ^ b_eff_s;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = $signed(a) >>> shamt;
      OP_SRL:  result = a >> shamt;
      default: result = {DATA_W{1'b0}};
    endcase
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one ALU core between two requesters with round-robin arbitration.
//   Flow: IDLE (grant + operand capture) -> EXEC (ALU on registered operands,
//   result capture) -> RESP (hold response to owner until consumed) -> IDLE.
//   Ports:
//     clk, reset             : clock, asynchronous active-high reset
//     req_valid / req_ready  : per-requester request handshake (bit i)
//     req_a/req_b            : operands, slice i per requester
//     req_op/req_bneg/req_shamt : ALU controls, slice/bit i per requester
//     resp_valid / resp_ready: per-requester response handshake (bit i)
//     resp_result/zero/ovf/cout : registered ALU result and flags
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*DATA_W-1:0]  req_a,
  input  logic [2*DATA_W-1:0]  req_b,
  input  logic [2*OP_W-1:0]    req_op,
  input  logic [1:0]           req_bneg,
  input  logic [2*SHAMT_W-1:0] req_shamt,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [DATA_W-1:0]    resp_result,
  output logic                 resp_zero,
  output logic                 resp_ovf,
  output logic                 resp_cout
);

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic                 bneg_q, bneg_d;
  logic [SHAMT_W-1:0]   shamt_q, shamt_d;
  logic [1:0]           resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 cout_q, cout_d;

  logic                 any_valid_s;
  logic                 grant_s;
  logic [DATA_W-1:0]    alu_result_s;
  logic                 alu_zero_s;
  logic                 alu_ovf_s;
  logic                 alu_cout_s;

  // The core only ever sees the registered operands.
  alu_core #(
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .SHAMT_W (SHAMT_W)
  ) u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .bneg   (bneg_q),
    .shamt  (shamt_q),
    .result (alu_result_s),
    .zero   (alu_zero_s),
    .ovf    (alu_ovf_s),
    .cout   (alu_cout_s)
  );

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    any_valid_s = |req_valid;
    case (req_valid)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ~last_q;
      default: grant_s = 1'b0;
    endcase
    if ((state_q == ST_IDLE) && any_valid_s) begin
      req_ready = id_onehot(grant_s);
    end else begin
      req_ready = 2'b00;
    end
  end

  // FSM next state, operand capture and response capture.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    bneg_d       = bneg_q;
    shamt_d      = shamt_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    cout_d       = cout_q;
    case (state_q)
      ST_IDLE: begin
        // The granted requester is always valid, so any valid means acceptance.
        if (any_valid_s) begin
          owner_d = grant_s;
          a_d     = grant_s ? req_a[2*DATA_W-1:DATA_W]      : req_a[DATA_W-1:0];
          b_d     = grant_s ? req_b[2*DATA_W-1:DATA_W]      : req_b[DATA_W-1:0];
          op_d    = grant_s ? req_op[2*OP_W-1:OP_W]         : req_op[OP_W-1:0];
          bneg_d  = grant_s ? req_bneg[1]                   : req_bneg[0];
          shamt_d = grant_s ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d     = alu_result_s;
        zero_d       = alu_zero_s;
        ovf_d        = alu_ovf_s;
        cout_d       = alu_cout_s;
        resp_valid_d = id_onehot(owner_q);
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's resp_ready can release the response.
        if (resp_ready[owner_q]) begin
          resp_valid_d = 2'b00;
          last_d       = owner_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp_valid_d = 2'b00;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      op_q         <= {OP_W{1'b0}};
      bneg_q       <= 1'b0;
      shamt_q      <= {SHAMT_W{1'b0}};
      resp_valid_q <= 2'b00;
      result_q     <= {DATA_W{1'b0}};
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      bneg_q       <= bneg_d;
      shamt_q      <= shamt_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      cout_q       <= cout_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_ovf    = ovf_q;
  assign resp_cout   = cout_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter: reset values, round-robin order,
//   latency, ALU results/flags, response stall and reset during EXEC.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  req_bneg;
  logic [7:0]  req_shamt;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_result;
  logic        resp_zero;
  logic        resp_ovf;
  logic        resp_cout;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_bneg    (req_bneg),
    .req_shamt   (req_shamt),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_ovf    (resp_ovf),
    .resp_cout   (resp_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic bneg, input logic [3:0] shamt);
    if (id == 0) begin
      req_a[15:0] = a; req_b[15:0] = b; req_op[2:0] = op;
      req_bneg[0] = bneg; req_shamt[3:0] = shamt;
    end else begin
      req_a[31:16] = a; req_b[31:16] = b; req_op[5:3] = op;
      req_bneg[1] = bneg; req_shamt[7:4] = shamt;
    end
  endtask

  // One isolated operation from requester id with resp_ready held high.
  task automatic run_single(input string tag, input int id,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] op, input logic bneg, input logic [3:0] shamt,
                            input logic [15:0] exp_res, input logic exp_z,
                            input logic exp_o, input logic exp_c);
    logic [1:0] oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    set_req(id, a, b, op, bneg, shamt);
    req_valid  = oh;
    resp_ready = 2'b11;
    #1;
    check({tag, "_req_ready"}, {30'd0, req_ready}, {30'd0, oh});
    tick();
    req_valid = 2'b00;
    check({tag, "_exec_valid"}, {30'd0, resp_valid}, 32'd0);
    tick();
    check({tag, "_resp_valid"}, {30'd0, resp_valid}, {30'd0, oh});
    check({tag, "_result"}, {16'd0, resp_result}, {16'd0, exp_res});
    check({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, exp_z});
    check({tag, "_ovf"}, {31'd0, resp_ovf}, {31'd0, exp_o});
    check({tag, "_cout"}, {31'd0, resp_cout}, {31'd0, exp_c});
    tick();
  endtask

  initial begin
    logic [1:0] exp_oh;
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_a      = 32'd0;
    req_b      = 32'd0;
    req_op     = 6'd0;
    req_bneg   = 2'b00;
    req_shamt  = 8'd0;
    #1;
    check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_result", {16'd0, resp_result}, 32'd0);
    check("rst_flags", {29'd0, resp_zero, resp_ovf, resp_cout}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Both valid: req0 ADD 3+4, req1 SUB 0x8000-1; grants alternate 0,1,0,1.
    set_req(0, 16'h0003, 16'h0004, 3'd0, 1'b0, 4'd0);
    set_req(1, 16'h8000, 16'h0001, 3'd1, 1'b1, 4'd0);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr_grant", {30'd0, req_ready}, {30'd0, exp_oh});
      tick();
      check("rr_exec_ready", {30'd0, req_ready}, 32'd0);
      check("rr_exec_valid", {30'd0, resp_valid}, 32'd0);
      tick();
      check("rr_resp_valid", {30'd0, resp_valid}, {30'd0, exp_oh});
      check("rr_resp_ready", {30'd0, req_ready}, 32'd0);
      if (k % 2 == 0) begin
        check("rr_add_result", {16'd0, resp_result}, 32'h0000_0007);
        check("rr_add_ovf", {31'd0, resp_ovf}, 32'd0);
      end else begin
        check("rr_sub_result", {16'd0, resp_result}, 32'h0000_7FFF);
        check("rr_sub_ovf", {31'd0, resp_ovf}, 32'd1);
        check("rr_sub_cout", {31'd0, resp_cout}, 32'd1);
      end
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Single-requester operations and boundary results.
    run_single("add", 0, 16'h0003, 16'h0004, 3'd0, 1'b0, 4'd0, 16'h0007, 1'b0, 1'b0, 1'b0);
    run_single("sll", 0, 16'h0001, 16'h0000, 3'd4, 1'b0, 4'd15, 16'h8000, 1'b0, 1'b0, 1'b0);
    run_single("sra", 0, 16'h8000, 16'h0000, 3'd5, 1'b0, 4'd15, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_single("and", 0, 16'hF0F0, 16'h0F0F, 3'd2, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_single("or", 1, 16'hF0F0, 16'h0F0F, 3'd3, 1'b0, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_single("addwrap", 0, 16'hFFFF, 16'h0001, 3'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Stall: req0 served last, so req1 wins; response held 10 cycles.
    set_req(1, 16'h8000, 16'h0001, 3'd1, 1'b1, 4'd0);
    req_valid  = 2'b11;
    resp_ready = 2'b00;
    #1;
    check("stall_grant", {30'd0, req_ready}, 32'd2);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_req_ready", {30'd0, req_ready}, 32'd0);
      check("stall_resp_valid", {30'd0, resp_valid}, 32'd2);
      check("stall_result", {16'd0, resp_result}, 32'h0000_7FFF);
      check("stall_flags", {29'd0, resp_zero, resp_ovf, resp_cout}, 32'd3);
      // Second half raises only the non-owner's ready, which must be ignored.
      resp_ready = (i < 5) ? 2'b00 : 2'b01;
      tick();
    end
    resp_ready = 2'b10;
    tick();
    check("release_valid", {30'd0, resp_valid}, 32'd0);
    check("release_grant", {30'd0, req_ready}, 32'd1);

    // Accept req0 (ADD 0xFFFF+1 still on its slice), then reset in EXEC.
    tick();
    req_valid = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    check("exec_rst_valid", {30'd0, resp_valid}, 32'd0);
    check("exec_rst_result", {16'd0, resp_result}, 32'd0);
    check("exec_rst_flags", {29'd0, resp_zero, resp_ovf, resp_cout}, 32'd0);
    check("exec_rst_ready", {30'd0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_no_resp", {30'd0, resp_valid}, 32'd0);
    req_valid = 2'b11;
    #1;
    check("post_rst_tie", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
